// File: rtl/block_memory_responder.sv
// Memory-side block responder for the data cache: serves 128-bit refills and write-backs
// over a read/write/busywait handshake with a fixed, parameterised access latency.
module block_memory_responder #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_writedata,
    output logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  mem_busywait
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ACCESS = 2'd1;
    localparam logic [1:0] STATE_DONE   = 2'd2;

    logic [1:0]            state_q,    state_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic                  op_write_q, op_write_d;
    logic [DEPTH_LOG2-1:0] idx_q,      idx_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Upper address bits only select an alias of the same block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[ADDR_WIDTH-1:DEPTH_LOG2];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        readdata_d = readdata_q;
        mem_we     = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (mem_read || mem_write) begin
                    // A simultaneous read and write is served as a write.
                    op_write_d = mem_write;
                    idx_d      = mem_address[DEPTH_LOG2-1:0];
                    wdata_d    = mem_writedata;
                    count_d    = CNT_W'(LATENCY - 1);
                    state_d    = STATE_ACCESS;
                end
            end
            STATE_ACCESS: begin
                if (count_q == '0) begin
                    if (op_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        readdata_d = mem_q[idx_q];
                    end
                    state_d = STATE_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            STATE_DONE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_busywait = 1'b0;
        case (state_q)
            STATE_IDLE:   mem_busywait = mem_read | mem_write;
            STATE_ACCESS: mem_busywait = 1'b1;
            default:      mem_busywait = 1'b0;
        endcase
    end

    assign mem_readdata = readdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= STATE_IDLE;
            count_q    <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
        end
    end

    // NOTE: the array is cleared by reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_block_memory_responder.sv
// Directed self-checking bench for block_memory_responder (LATENCY = 5).
module tb_block_memory_responder;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int n_assert = 0;
    int n_fail   = 0;
    int busy;

    localparam logic [127:0] D3  = 128'h4444_3333_2222_1111_8888_7777_6666_5555;
    localparam logic [127:0] D10 = 128'hA0A0_A0A0_1010_1010_0F0F_0F0F_1234_5678;
    localparam logic [127:0] D20 = 128'hB2B2_2020_C3C3_2020_D4D4_2020_E5E5_2020;
    localparam logic [127:0] DA  = 128'hDEAD_BEEF_0000_0030_CAFE_F00D_0000_0030;
    localparam logic [127:0] DB  = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
    localparam logic [127:0] D5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [127:0] DX  = 128'h0105_0105_FACE_B00C_0105_0105_FACE_B00C;
    localparam logic [127:0] DY  = 128'h7777_0007_7777_0007_7777_0007_7777_0007;

    block_memory_responder dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Counts consecutive sampled cycles with busywait high, starting at the current sample point.
    task automatic count_busy(output int cycles);
        cycles = 0;
        while (mem_busywait === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clock);
            #1;
        end
    endtask

    // Full transaction; returns in the DONE cycle with requests already dropped.
    task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data, output int cycles);
        @(negedge clock);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
        #1;
        count_busy(cycles);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        #12;
        check("reset_busywait", 128'(mem_busywait), 128'd0);
        check("reset_readdata", mem_readdata, 128'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1. Read of a cleared block after reset
        txn(1'b1, 1'b0, 28'h0000003, '0, busy);
        check("t1_busy_cycles", 128'(busy), 128'd6);
        check("t1_readdata", mem_readdata, 128'd0);

        // 2. Write then read back; the write leaves readdata alone
        txn(1'b0, 1'b1, 28'h0000003, D3, busy);
        check("t2_write_busy", 128'(busy), 128'd6);
        check("t2_write_keeps_rd", mem_readdata, 128'd0);
        txn(1'b1, 1'b0, 28'h0000003, '0, busy);
        check("t2_read_busy", 128'(busy), 128'd6);
        check("t2_readback", mem_readdata, D3);

        // 3. Write-back of 0x10 followed by refill of 0x20 with the request held through DONE
        txn(1'b0, 1'b1, 28'h0000020, D20, busy);
        @(negedge clock);
        mem_write     = 1'b1;
        mem_address   = 28'h0000010;
        mem_writedata = D10;
        #1;
        count_busy(busy);
        check("t3_wb_busy", 128'(busy), 128'd6);
        check("t3_gap_low", 128'(mem_busywait), 128'd0);
        mem_write   = 1'b0;
        mem_read    = 1'b1;
        mem_address = 28'h0000020;
        @(negedge clock);
        #1;
        check("t3_gap_one_cycle", 128'(mem_busywait), 128'd1);
        count_busy(busy);
        mem_read = 1'b0;
        check("t3_refill_busy", 128'(busy), 128'd6);
        check("t3_refill_data", mem_readdata, D20);
        @(negedge clock);
        #1;
        check("t3_no_third_txn", 128'(mem_busywait), 128'd0);
        txn(1'b1, 1'b0, 28'h0000010, '0, busy);
        check("t3_wb_committed", mem_readdata, D10);

        // 4. Inputs change and write drops after two ACCESS cycles
        @(negedge clock);
        mem_write     = 1'b1;
        mem_address   = 28'h0000030;
        mem_writedata = DA;
        @(negedge clock);
        @(negedge clock);
        mem_write     = 1'b0;
        mem_address   = 28'h0000031;
        mem_writedata = DB;
        #1;
        count_busy(busy);
        check("t4_remaining_busy", 128'(busy), 128'd4);
        txn(1'b1, 1'b0, 28'h0000030, '0, busy);
        check("t4_latched_block", mem_readdata, DA);
        txn(1'b1, 1'b0, 28'h0000031, '0, busy);
        check("t4_other_untouched", mem_readdata, 128'd0);
        txn(1'b1, 1'b0, 28'h0000030, '0, busy);
        check("t4_reread_latched", mem_readdata, DA);

        // 5. Reset in ACCESS cycle 3 of a write to 0x05
        @(negedge clock);
        mem_write     = 1'b1;
        mem_address   = 28'h0000005;
        mem_writedata = D5;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b1;
        mem_write = 1'b0;
        #1;
        check("t5_busy_on_reset", 128'(mem_busywait), 128'd0);
        check("t5_readdata_cleared", mem_readdata, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        txn(1'b1, 1'b0, 28'h0000005, '0, busy);
        check("t5_aborted_write", mem_readdata, 128'd0);
        check("t5_busy_after_reset", 128'(busy), 128'd6);
        txn(1'b1, 1'b0, 28'h0000030, '0, busy);
        check("t5_array_cleared", mem_readdata, 128'd0);

        // 6. Aliasing, then read and write together
        txn(1'b0, 1'b1, 28'h0000105, DX, busy);
        txn(1'b1, 1'b0, 28'h0000005, '0, busy);
        check("t6_alias_read", mem_readdata, DX);
        txn(1'b1, 1'b1, 28'h0000007, DY, busy);
        check("t6_both_busy", 128'(busy), 128'd6);
        check("t6_both_keeps_rd", mem_readdata, DX);
        txn(1'b1, 1'b0, 28'h0000007, '0, busy);
        check("t6_both_wrote", mem_readdata, DY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
